// File: rtl/mil_tx_arbiter.sv
// -----------------------------------------------------------------------------
// mil_tx_arbiter
//
// Two-requester arbiter and message sequencer in front of the MIL-STD-1553
// transceiver transmit push port. One requester owns the transceiver for a
// whole message (first word up to the word flagged last). Every word is
// forwarded over the tx push handshake. A minimum idle gap separates
// messages. The owner must present its next word within WORD_TIMEOUT cycles.
// A new message never starts while the receiver reports line activity.
//
// Handshakes (valid/ready semantics used on every port pair):
//   reqN_request is the requester's valid. It is held high with type/word/last
//   stable until reqN_done pulses for one cycle. tx_request is our valid
//   towards the transceiver. It is held high with tx_type/tx_word stable until
//   tx_done pulses for one cycle, which is the ready/complete strobe. A word
//   transfers exactly once per done pulse.
//
// Ports:
//   clk, nRst                      clock, asynchronous active-low reset
//   reqN_request/type/word/last    requester N word offer (N = 0, 1)
//   reqN_done                      one-cycle pulse: requester N word sent
//   tx_request/tx_type/tx_word     push port towards the transceiver
//   tx_done                        one-cycle pulse: transceiver took the word
//   rx_busy                        receiver active; blocks message start only
//   grant                          one-hot owner (01 req0, 10 req1, 00 none)
//   timeout_err                    one-cycle pulse: owner timed out in HOLD
//   o_dbg_state                    current FSM state (IDLE/SEND/HOLD/GAP)
//   o_dbg_rptr                     round-robin pointer (preferred requester)
// -----------------------------------------------------------------------------
module mil_tx_arbiter #(
    parameter int GAP_CYCLES   = 400,
    parameter int WORD_TIMEOUT = 2000
) (
    input  logic        clk,
    input  logic        nRst,

    input  logic        req0_request,
    input  logic [1:0]  req0_type,
    input  logic [15:0] req0_word,
    input  logic        req0_last,
    output logic        req0_done,

    input  logic        req1_request,
    input  logic [1:0]  req1_type,
    input  logic [15:0] req1_word,
    input  logic        req1_last,
    output logic        req1_done,

    output logic        tx_request,
    output logic [1:0]  tx_type,
    output logic [15:0] tx_word,
    input  logic        tx_done,

    input  logic        rx_busy,
    output logic [1:0]  grant,
    output logic        timeout_err,

    output logic [1:0]  o_dbg_state,
    output logic        o_dbg_rptr
);

    // Counter widths: ceil(log2(max+1)), at least one bit.
    localparam int GAP_W = (GAP_CYCLES < 1) ? 1 : $clog2(GAP_CYCLES + 1);
    localparam int TMO_W = (WORD_TIMEOUT < 1) ? 1 : $clog2(WORD_TIMEOUT + 1);

    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES);
    localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(WORD_TIMEOUT);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SEND = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;
    localparam logic [1:0] S_GAP  = 2'd3;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [1:0]       r_state;
    logic             r_rptr;
    logic [1:0]       r_grant;
    logic             r_tx_request;
    logic [1:0]       r_tx_type;
    logic [15:0]      r_tx_word;
    logic             r_last;
    logic             r_done0;
    logic             r_done1;
    logic             r_done0_d;
    logic             r_done1_d;
    logic             r_timeout;
    logic [GAP_W-1:0] r_gap_cnt;
    logic [TMO_W-1:0] r_tmo_cnt;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic             w_elig0;
    logic             w_elig1;
    logic             w_rr_pick1;
    logic             w_sel1;
    logic [1:0]       w_sel_type;
    logic [15:0]      w_sel_word;
    logic             w_sel_last;
    logic             w_owner_elig;
    logic             w_gap_last;
    logic             w_tmo_last;

    logic [1:0]       w_state_nxt;
    logic             w_start;      // latch selected word and raise tx_request
    logic             w_word_sent;  // tx_done accepted in SEND
    logic             w_msg_end;    // leaving the message (last word or timeout)
    logic             w_timeout;

    // A request is ignored while its done pulse is high and for one more
    // cycle, so a requester that drops request after done is never
    // latched twice for the same word.
    assign w_elig0 = req0_request & ~r_done0 & ~r_done0_d;
    assign w_elig1 = req1_request & ~r_done1 & ~r_done1_d;

    // Requester 1 wins when it is alone, or when both are pending and the
    // round-robin pointer favours it.
    assign w_rr_pick1 = w_elig1 & (~w_elig0 | r_rptr);

    // In HOLD only the current owner may continue; in IDLE arbitration decides.
    assign w_sel1     = (r_state == S_HOLD) ? r_grant[1] : w_rr_pick1;
    assign w_sel_type = w_sel1 ? req1_type : req0_type;
    assign w_sel_word = w_sel1 ? req1_word : req0_word;
    assign w_sel_last = w_sel1 ? req1_last : req0_last;

    assign w_owner_elig = r_grant[1] ? w_elig1 : w_elig0;

    // A counter at 1 reaches 0 on this edge; one already at 0 is saturated.
    assign w_gap_last = (r_gap_cnt <= GAP_W'(1));
    assign w_tmo_last = (r_tmo_cnt <= TMO_W'(1));

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_word_sent = 1'b0;
        w_msg_end   = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!rx_busy && (w_elig0 || w_elig1)) begin
                    w_state_nxt = S_SEND;
                    w_start     = 1'b1;
                end
            end
            S_SEND: begin
                // rx_busy is deliberately ignored once a message is running.
                if (tx_done) begin
                    w_word_sent = 1'b1;
                    if (r_last) begin
                        w_state_nxt = S_GAP;
                        w_msg_end   = 1'b1;
                    end else begin
                        w_state_nxt = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                // The owner's next word takes priority over an expiring timer.
                if (w_owner_elig) begin
                    w_state_nxt = S_SEND;
                    w_start     = 1'b1;
                end else if (w_tmo_last) begin
                    w_state_nxt = S_GAP;
                    w_msg_end   = 1'b1;
                    w_timeout   = 1'b1;
                end
            end
            S_GAP: begin
                // The gap runs regardless of rx_busy.
                if (w_gap_last) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Push port and latched word
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            r_tx_request <= 1'b0;
            r_tx_type    <= 2'd0;
            r_tx_word    <= 16'd0;
            r_last       <= 1'b0;
        end else begin
            if (w_start) begin
                r_tx_request <= 1'b1;
                r_tx_type    <= w_sel_type;
                r_tx_word    <= w_sel_word;
                r_last       <= w_sel_last;
            end else if (w_word_sent) begin
                r_tx_request <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Ownership and round-robin pointer
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            r_grant <= 2'b00;
            r_rptr  <= 1'b0;
        end else begin
            if (w_start) begin
                r_grant <= w_sel1 ? 2'b10 : 2'b01;
            end else if (w_msg_end) begin
                // Next contest favours whoever did not own this message.
                r_grant <= 2'b00;
                r_rptr  <= ~r_grant[1];
            end
        end
    end

    // ------------------------------------------------------------------
    // Done pulses, their one-cycle shadows, timeout pulse
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            r_done0   <= 1'b0;
            r_done1   <= 1'b0;
            r_done0_d <= 1'b0;
            r_done1_d <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_done0   <= w_word_sent & ~r_grant[1];
            r_done1   <= w_word_sent &  r_grant[1];
            r_done0_d <= r_done0;
            r_done1_d <= r_done1;
            r_timeout <= w_timeout;
        end
    end

    // ------------------------------------------------------------------
    // Inter-message gap counter (reset to 0: first message needs no gap)
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            r_gap_cnt <= '0;
        end else begin
            if (w_msg_end) begin
                r_gap_cnt <= GAP_LOAD;
            end else if (r_state == S_GAP) begin
                r_gap_cnt <= w_gap_last ? '0 : (r_gap_cnt - GAP_W'(1));
            end
        end
    end

    // ------------------------------------------------------------------
    // Per-word timeout counter, loaded on entry to HOLD
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            r_tmo_cnt <= '0;
        end else begin
            if (w_word_sent && !r_last) begin
                r_tmo_cnt <= TMO_LOAD;
            end else if ((r_state == S_HOLD) && !w_start) begin
                r_tmo_cnt <= w_tmo_last ? '0 : (r_tmo_cnt - TMO_W'(1));
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign tx_request  = r_tx_request;
    assign tx_type     = r_tx_type;
    assign tx_word     = r_tx_word;
    assign grant       = r_grant;
    assign req0_done   = r_done0;
    assign req1_done   = r_done1;
    assign timeout_err = r_timeout;
    assign o_dbg_state = r_state;
    assign o_dbg_rptr  = r_rptr;

endmodule

// File: tb/tb_mil_tx_arbiter.sv
module tb_mil_tx_arbiter;

    localparam int GAP = 400;
    localparam int TMO = 2000;

    localparam logic [1:0] WCOMMAND = 2'd0;
    localparam logic [1:0] WSTATUS  = 2'd1;
    localparam logic [1:0] WDATA    = 2'd2;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;
    localparam logic [1:0] ST_GAP  = 2'd3;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        nRst;
    logic        req0_request, req0_last, req0_done;
    logic [1:0]  req0_type;
    logic [15:0] req0_word;
    logic        req1_request, req1_last, req1_done;
    logic [1:0]  req1_type;
    logic [15:0] req1_word;
    logic        tx_request, tx_done, rx_busy, timeout_err;
    logic [1:0]  tx_type, grant;
    logic [15:0] tx_word;
    logic [1:0]  dbg_state;
    logic        dbg_rptr;

    always #5 clk = ~clk;

    mil_tx_arbiter #(.GAP_CYCLES(GAP), .WORD_TIMEOUT(TMO)) dut (
        .clk          (clk),
        .nRst         (nRst),
        .req0_request (req0_request),
        .req0_type    (req0_type),
        .req0_word    (req0_word),
        .req0_last    (req0_last),
        .req0_done    (req0_done),
        .req1_request (req1_request),
        .req1_type    (req1_type),
        .req1_word    (req1_word),
        .req1_last    (req1_last),
        .req1_done    (req1_done),
        .tx_request   (tx_request),
        .tx_type      (tx_type),
        .tx_word      (tx_word),
        .tx_done      (tx_done),
        .rx_busy      (rx_busy),
        .grant        (grant),
        .timeout_err  (timeout_err),
        .o_dbg_state  (dbg_state),
        .o_dbg_rptr   (dbg_rptr)
    );

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_errors = 0;

    // Scoreboard: {req1_done, req0_done, tx_word} expected at each done pulse.
    logic [17:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (nRst && (req0_done || req1_done)) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_done", 32'({req1_done, req0_done, tx_word}), 32'h3ffff);
            end else begin
                check("sb_done_word", 32'({req1_done, req0_done, tx_word}), 32'(exp_q.pop_front()));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait until tx_request is high; n = ticks spent.
    task automatic wait_tx(input int budget, output int n);
        n = 0;
        while (!tx_request && n < budget) begin
            tick();
            n++;
        end
        check("wait_tx_request", 32'(tx_request), 32'd1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (dbg_state != ST_IDLE && n < GAP + TMO + 10) begin
            tick();
            n++;
        end
        check("wait_idle", 32'(dbg_state), 32'(ST_IDLE));
    endtask

    // Transceiver side: tx_request is already high. Checks the word, pulses
    // tx_done, checks the owner's done pulse and the dropped tx_request.
    task automatic serve(input string tag, input logic [1:0] e_grant,
                         input logic [15:0] e_word, input logic [1:0] e_type);
        check({tag, "_grant"}, 32'(grant), 32'(e_grant));
        check({tag, "_word"}, 32'(tx_word), 32'(e_word));
        check({tag, "_type"}, 32'(tx_type), 32'(e_type));
        exp_q.push_back({e_grant, e_word});
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        check({tag, "_done"}, 32'({req1_done, req0_done}), 32'(e_grant));
        check({tag, "_txreq_drop"}, 32'(tx_request), 32'd0);
    endtask

    task automatic set_req0(input logic r, input logic [1:0] t, input logic [15:0] w, input logic l);
        req0_request = r; req0_type = t; req0_word = w; req0_last = l;
    endtask

    task automatic set_req1(input logic r, input logic [1:0] t, input logic [15:0] w, input logic l);
        req1_request = r; req1_type = t; req1_word = w; req1_last = l;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        r0;
        logic [1:0]  t0;
        logic [15:0] w0;
        logic        r1;
        logic [1:0]  t1;
        logic [15:0] w1;
        logic [1:0]  e_grant;
        logic [15:0] e_word;
        logic [1:0]  e_type;
        logic        e_rptr;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int n;
        logic ok;

        // Single-word messages; rptr is 0 when the table starts.
        vecs[0] = '{1'b1, WCOMMAND, 16'h1234, 1'b0, WCOMMAND, 16'h0000, 2'b01, 16'h1234, WCOMMAND, 1'b1};
        vecs[1] = '{1'b1, WDATA,    16'hAAAA, 1'b1, WDATA,    16'hBBBB, 2'b10, 16'hBBBB, WDATA,    1'b0};
        vecs[2] = '{1'b1, WDATA,    16'h0F0F, 1'b1, WSTATUS,  16'hF0F0, 2'b01, 16'h0F0F, WDATA,    1'b1};
        vecs[3] = '{1'b0, WCOMMAND, 16'h0000, 1'b1, WDATA,    16'hFFFF, 2'b10, 16'hFFFF, WDATA,    1'b0};
        vecs[4] = '{1'b0, WCOMMAND, 16'h0000, 1'b1, WCOMMAND, 16'h0001, 2'b10, 16'h0001, WCOMMAND, 1'b0};
        vecs[5] = '{1'b1, WSTATUS,  16'h8000, 1'b1, WDATA,    16'h7FFF, 2'b01, 16'h8000, WSTATUS,  1'b1};

        nRst = 1'b0;
        set_req0(1'b0, 2'd0, 16'd0, 1'b0);
        set_req1(1'b0, 2'd0, 16'd0, 1'b0);
        tx_done = 1'b0;
        rx_busy = 1'b0;
        #2;

        // ---- reset state ----
        check("rst_tx_request", 32'(tx_request), 32'd0);
        check("rst_tx_word", 32'({tx_type, tx_word}), 32'd0);
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_done_tmo", 32'({req0_done, req1_done, timeout_err}), 32'd0);
        check("rst_state_rptr", 32'({dbg_state, dbg_rptr}), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        nRst = 1'b1;

        // ---- both request together after reset ----
        set_req0(1'b1, WDATA, 16'hAAAA, 1'b1);
        set_req1(1'b1, WDATA, 16'hBBBB, 1'b1);
        tick();
        check("both_first_txreq", 32'(tx_request), 32'd1);
        serve("both_r0", 2'b01, 16'hAAAA, WDATA);
        req0_request = 1'b0;
        wait_tx(GAP + 20, n);
        check("both_r1_latency", 32'(n + 1), 32'(GAP + 2));
        serve("both_r1", 2'b10, 16'hBBBB, WDATA);
        req1_request = 1'b0;
        check("both_rptr_end", 32'(dbg_rptr), 32'd0);
        wait_idle();

        // ---- two-word message from req0, exact gap ----
        set_req0(1'b1, WCOMMAND, 16'h1111, 1'b0);
        tick();
        check("msg_w1_txreq", 32'(tx_request), 32'd1);
        serve("msg_w1", 2'b01, 16'h1111, WCOMMAND);
        check("msg_hold", 32'(dbg_state), 32'(ST_HOLD));
        req0_request = 1'b0;
        tick();
        set_req0(1'b1, WDATA, 16'h2222, 1'b1);
        wait_tx(10, n);
        serve("msg_w2", 2'b01, 16'h2222, WDATA);
        req0_request = 1'b0;
        check("msg_gap_grant", 32'({dbg_state, grant}), 32'({ST_GAP, 2'b00}));
        repeat (GAP - 1) tick();
        check("msg_gap_still", 32'(dbg_state), 32'(ST_GAP));
        tick();
        check("msg_idle_401", 32'({dbg_state, grant}), 32'({ST_IDLE, 2'b00}));

        // ---- req1 arrives while req0 holds ----
        set_req0(1'b1, WCOMMAND, 16'h1111, 1'b0);
        tick();
        check("hold_w1_txreq", 32'(tx_request), 32'd1);
        serve("hold_w1", 2'b01, 16'h1111, WCOMMAND);
        req0_request = 1'b0;
        set_req1(1'b1, WSTATUS, 16'hCCCC, 1'b1);
        ok = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (grant != 2'b01 || tx_request) ok = 1'b0;
        end
        check("hold_ignores_req1", 32'(ok), 32'd1);
        set_req0(1'b1, WDATA, 16'h2222, 1'b1);
        wait_tx(10, n);
        serve("hold_w2", 2'b01, 16'h2222, WDATA);
        req0_request = 1'b0;
        wait_tx(GAP + 20, n);
        check("hold_r1_latency", 32'(n + 1), 32'(GAP + 2));
        serve("hold_r1", 2'b10, 16'hCCCC, WSTATUS);
        req1_request = 1'b0;
        wait_idle();

        // ---- table-driven single-word messages ----
        for (int v = 0; v < 6; v++) begin
            set_req0(vecs[v].r0, vecs[v].t0, vecs[v].w0, 1'b1);
            set_req1(vecs[v].r1, vecs[v].t1, vecs[v].w1, 1'b1);
            tick();
            check($sformatf("vec%0d_txreq", v), 32'(tx_request), 32'd1);
            serve($sformatf("vec%0d", v), vecs[v].e_grant, vecs[v].e_word, vecs[v].e_type);
            req0_request = 1'b0;
            req1_request = 1'b0;
            check($sformatf("vec%0d_rptr", v), 32'(dbg_rptr), 32'(vecs[v].e_rptr));
            repeat (GAP) tick();
            check($sformatf("vec%0d_idle", v), 32'(dbg_state), 32'(ST_IDLE));
        end

        // ---- owner timeout ----
        set_req0(1'b1, WCOMMAND, 16'h5555, 1'b0);
        tick();
        check("tmo_txreq", 32'(tx_request), 32'd1);
        serve("tmo_w1", 2'b01, 16'h5555, WCOMMAND);
        req0_request = 1'b0;
        set_req1(1'b1, WDATA, 16'hDDDD, 1'b1);
        ok = 1'b1;
        for (int i = 0; i < TMO - 1; i++) begin
            tick();
            if (timeout_err || grant != 2'b01 || tx_request) ok = 1'b0;
        end
        check("tmo_quiet", 32'(ok), 32'd1);
        tick();
        check("tmo_pulse", 32'(timeout_err), 32'd1);
        check("tmo_grant_state", 32'({grant, dbg_state}), 32'({2'b00, ST_GAP}));
        check("tmo_rptr", 32'(dbg_rptr), 32'd1);
        tick();
        check("tmo_pulse_end", 32'(timeout_err), 32'd0);
        wait_tx(GAP + 20, n);
        check("tmo_r1_latency", 32'(n + 1), 32'(GAP + 1));
        serve("tmo_r1", 2'b10, 16'hDDDD, WDATA);
        req1_request = 1'b0;
        wait_idle();

        // ---- rx_busy blocks message start only ----
        rx_busy = 1'b1;
        set_req0(1'b1, WSTATUS, 16'hEEEE, 1'b1);
        ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (tx_request) ok = 1'b0;
        end
        check("busy_blocks", 32'(ok), 32'd1);
        rx_busy = 1'b0;
        tick();
        check("busy_release_txreq", 32'(tx_request), 32'd1);
        rx_busy = 1'b1;
        tick();
        check("busy_in_send", 32'({tx_request, dbg_state}), 32'({1'b1, ST_SEND}));
        serve("busy", 2'b01, 16'hEEEE, WSTATUS);
        req0_request = 1'b0;
        rx_busy = 1'b0;
        wait_idle();

        // ---- asynchronous reset during SEND ----
        set_req0(1'b1, WDATA, 16'h9999, 1'b1);
        tick();
        check("rstx_txreq", 32'(tx_request), 32'd1);
        #2;
        nRst = 1'b0;
        #1;
        check("rstx_txreq_drop", 32'(tx_request), 32'd0);
        check("rstx_word_type", 32'({tx_type, tx_word}), 32'd0);
        check("rstx_grant_state", 32'({grant, dbg_state}), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        nRst = 1'b1;
        tick();
        check("rstx_restart", 32'(tx_request), 32'd1);
        serve("rstx", 2'b01, 16'h9999, WDATA);
        req0_request = 1'b0;
        repeat (3) tick();

        // ---- final report ----
        check("sb_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
